ace_snoop_ctrl: RTL and testbench
=================================

ACE_SNOOP_CTRL -- requirements
Module: ace_snoop_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 64, CD beat width in bits (power of two, at least 64).
REQ-002 SHALL have parameter LINE_W, default 128, cache line width in bits; BEATS=LINE_W/DATA_W, at least 1.
REQ-003 SHALL have parameter WAYS, default 8, set associativity.
REQ-004 SHALL have parameters INDEX_W, default 12, and TAG_W, default 44; INDEX_W includes line-offset bits.
REQ-005 SHALL have port clk_i, input, 1, clock.
REQ-006 SHALL have port rst_ni, input, 1, reset (asynchronous, active-low).
REQ-007 SHALL have ports bypass_i input 1 (cache disabled) and busy_o output 1 (state not IDLE).
REQ-008 SHALL have ports ac_valid_i input 1, ac_ready_o output 1, ac_addr_i input INDEX_W+TAG_W, ac_snoop_i input 4.
REQ-009 SHALL have ports cr_valid_o output 1, cr_ready_i input 1, cr_resp_o output 5, packed {WasUnique,IsShared,PassDirty,Error,DataTransfer}.
REQ-010 SHALL have ports cd_valid_o output 1, cd_ready_i input 1, cd_data_o output DATA_W, cd_last_o output 1.
REQ-011 SHALL have SRAM ports req_o output WAYS, addr_o output INDEX_W, tag_o output TAG_W, gnt_i input 1, data_i input WAYS*LINE_W, hit_way_i, dirty_way_i and shared_way_i each input WAYS.
REQ-012 SHALL have state-update ports upd_valid_o output 1, upd_op_o output 1 (0=INVALIDATE, 1=MAKE_SHARED_CLEAN), upd_addr_o output INDEX_W+TAG_W, upd_gnt_i input 1.

Function
REQ-013 SHALL use FSM states IDLE, WAIT_GNT, LOOKUP, UPDATE, SEND_CR, SEND_CD and assert ac_ready_o only in IDLE.
REQ-014 SHALL latch ac_addr_i and ac_snoop_i on the AC handshake; addr_o and tag_o SHALL take their values from the incoming address in the handshake cycle, then from the latched address.
REQ-015 SHALL go to SEND_CR with cr_resp_o=0 on handshake when bypass_i=1, with no SRAM request.
REQ-016 SHALL accept ReadOnce 0000, ReadShared 0001, ReadUnique 0111, CleanShared 1000, CleanInvalid 1001 and MakeInvalid 1101; any other code SHALL go to SEND_CR with Error=1 and all other bits 0.
REQ-017 SHALL, for a supported code, assert req_o to all ways from the handshake cycle until gnt_i, then enter LOOKUP one cycle later with hit, dirty and shared sampled.
REQ-018 SHALL, on miss, send cr_resp_o=0 with no update and no data.
REQ-019 SHALL, on hit, apply: ReadOnce DT=1 PD=0 IS=1 with no update; ReadShared DT=1 PD=dirty IS=1 with MAKE_SHARED_CLEAN; CleanShared DT=PD=dirty IS=1 with MAKE_SHARED_CLEAN; ReadUnique DT=1 PD=dirty IS=0 with INVALIDATE; CleanInvalid DT=PD=dirty IS=0 with INVALIDATE; MakeInvalid DT=PD=0 IS=0 with INVALIDATE.
REQ-020 SHALL set WasUnique=hit AND NOT shared for every hit.
REQ-021 SHALL capture the hit way's full line into a LINE_W register in LOOKUP.
REQ-022 SHALL hold upd_valid_o in UPDATE until upd_gnt_i, and SHALL issue CR only after the update is granted.
REQ-023 SHALL hold cr_valid_o and cr_resp_o stable until cr_ready_i; if DT=0 the FSM SHALL then return to IDLE, otherwise enter SEND_CD.
REQ-024 SHALL emit BEATS CD beats in wrapping order, starting at beat ac_addr[log2(LINE_W/8)-1:log2(DATA_W/8)] and wrapping modulo BEATS, with cd_last_o on the final beat only.
REQ-025 SHALL advance the beat counter only on cd_valid_o AND cd_ready_i, and SHALL hold data stable under backpressure; when BEATS=1 the single beat SHALL carry last.
REQ-026 SHALL ignore ac_valid_i while busy; a new snoop SHALL be accepted in the cycle after the final CR or CD handshake.

Reset
REQ-027 SHALL reset asynchronously to IDLE with all registers zero; all outputs SHALL be 0 except ac_ready_o=1.
REQ-028 SHALL, on reset mid-operation, abandon the transaction with no partial update, CR or CD.

Structure
REQ-029 SHALL place the snoop opcode enumeration, crresp_t and the update-op type in the shared snoop_pkg.
REQ-030 SHALL instantiate one sub-module, snoop_cd_serializer, containing the line register, wrapping beat counter and CD handshake.

Verification
REQ-031 Hit, clean, unique way: ReadShared at 0x1008, DATA_W=64, LINE_W=128 -> one MAKE_SHARED_CLEAN update, cr_resp_o=5'b11001, CD beats line[127:64] then line[63:0], last on the second beat.
REQ-032 Dirty hit: CleanInvalid -> INVALIDATE granted before CR, cr_resp_o=5'b10101, 2 beats; clean hit -> cr_resp_o=5'b10000, no CD.
REQ-033 Unsupported snoop 0010 -> cr_resp_o=5'b00010, no req_o, no upd_valid_o.
REQ-034 bypass_i=1 ReadUnique -> cr_resp_o=0 within 2 cycles of the handshake, req_o never asserted.
REQ-035 DATA_W=64, LINE_W=512, offset 0x30, cd_ready_i toggling -> beats 6,7,0..5 in order, data held stable while stalled, last only on beat 5.
REQ-036 rst_ni asserted during SEND_CD -> next cycle IDLE, cd_valid_o=0, ac_ready_o=1.

Source files
------------

// File: rtl/snoop_pkg.sv
// Shared ACE snoop types: snoop opcodes, CR response layout, state-update ops, controller states.
package snoop_pkg;

    typedef enum logic [3:0] {
        SNP_READ_ONCE     = 4'b0000,
        SNP_READ_SHARED   = 4'b0001,
        SNP_READ_UNIQUE   = 4'b0111,
        SNP_CLEAN_SHARED  = 4'b1000,
        SNP_CLEAN_INVALID = 4'b1001,
        SNP_MAKE_INVALID  = 4'b1101
    } snoop_e;

    typedef struct packed {
        logic was_unique;
        logic is_shared;
        logic pass_dirty;
        logic error;
        logic data_transfer;
    } crresp_t;

    typedef enum logic {
        UPD_INVALIDATE        = 1'b0,
        UPD_MAKE_SHARED_CLEAN = 1'b1
    } upd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_GNT,
        ST_LOOKUP,
        ST_UPDATE,
        ST_SEND_CR,
        ST_SEND_CD
    } state_e;

    function automatic logic snoop_supported(input logic [3:0] code);
        case (code)
            SNP_READ_ONCE, SNP_READ_SHARED, SNP_READ_UNIQUE,
            SNP_CLEAN_SHARED, SNP_CLEAN_INVALID, SNP_MAKE_INVALID: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/snoop_cd_serializer.sv
// Holds one cache line and streams it as DATA_W beats in wrapping order, one beat per CD handshake.
// Data and last stay stable while cd_ready_i is low; done_o pulses on the final beat's handshake.
module snoop_cd_serializer #(
    parameter  int unsigned DATA_W = 64,
    parameter  int unsigned LINE_W = 128,
    localparam int unsigned BEATS  = LINE_W / DATA_W,
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [LINE_W-1:0] line_i,
    input  logic [BEAT_W-1:0] start_beat_i,
    input  logic              en_i,
    input  logic              cd_ready_i,
    output logic              cd_valid_o,
    output logic [DATA_W-1:0] cd_data_o,
    output logic              cd_last_o,
    output logic              done_o
);

    logic [LINE_W-1:0] line_q, line_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [BEAT_W:0]   cnt_q, cnt_d;
    logic              hs;

    assign hs         = en_i & cd_ready_i;
    assign cd_valid_o = en_i;
    assign cd_last_o  = en_i & (cnt_q == (BEAT_W+1)'(BEATS - 1));
    assign cd_data_o  = en_i ? line_q[int'(beat_q)*DATA_W +: DATA_W] : '0;
    assign done_o     = hs & cd_last_o;

    always_comb begin
        line_d = line_q;
        beat_d = beat_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            line_d = line_i;
            beat_d = start_beat_i;
            cnt_d  = '0;
        end else if (hs) begin
            // explicit wrap keeps BEATS=1 (single-bit counter) correct
            beat_d = (beat_q == BEAT_W'(BEATS - 1)) ? '0 : beat_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            line_q <= '0;
            beat_q <= '0;
            cnt_q  <= '0;
        end else begin
            line_q <= line_d;
            beat_q <= beat_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/ace_snoop_ctrl.sv
// ACE snoop controller: accepts one AC snoop, looks up the cache, updates line state, returns CR then CD.
// One snoop in flight; ac_ready_o only in IDLE, every downstream channel holds until its ready/grant.
module ace_snoop_ctrl
    import snoop_pkg::*;
#(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned LINE_W  = 128,
    parameter int unsigned WAYS    = 8,
    parameter int unsigned INDEX_W = 12,
    parameter int unsigned TAG_W   = 44
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     bypass_i,
    output logic                     busy_o,
    input  logic                     ac_valid_i,
    output logic                     ac_ready_o,
    input  logic [INDEX_W+TAG_W-1:0] ac_addr_i,
    input  logic [3:0]               ac_snoop_i,
    output logic                     cr_valid_o,
    input  logic                     cr_ready_i,
    output logic [4:0]               cr_resp_o,
    output logic                     cd_valid_o,
    input  logic                     cd_ready_i,
    output logic [DATA_W-1:0]        cd_data_o,
    output logic                     cd_last_o,
    output logic [WAYS-1:0]          req_o,
    output logic [INDEX_W-1:0]       addr_o,
    output logic [TAG_W-1:0]         tag_o,
    input  logic                     gnt_i,
    input  logic [WAYS*LINE_W-1:0]   data_i,
    input  logic [WAYS-1:0]          hit_way_i,
    input  logic [WAYS-1:0]          dirty_way_i,
    input  logic [WAYS-1:0]          shared_way_i,
    output logic                     upd_valid_o,
    output logic                     upd_op_o,
    output logic [INDEX_W+TAG_W-1:0] upd_addr_o,
    input  logic                     upd_gnt_i
);

    localparam int unsigned AW     = INDEX_W + TAG_W;
    localparam int unsigned BEATS  = LINE_W / DATA_W;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFF_LO = $clog2(DATA_W / 8);

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [3:0]        snoop_q, snoop_d;
    crresp_t           resp_q, resp_d;
    upd_op_e           upd_op_q, upd_op_d;

    logic              ac_hs, hit, dirty, shared, need_upd, load, cd_done;
    crresp_t           hit_resp;
    upd_op_e           hit_op;
    logic [LINE_W-1:0] hit_line;
    logic [BEAT_W-1:0] start_beat;

    assign ac_hs  = (state_q == ST_IDLE) & ac_valid_i;
    assign hit    = |hit_way_i;
    assign dirty  = |(hit_way_i & dirty_way_i);
    assign shared = |(hit_way_i & shared_way_i);

    always_comb begin
        hit_line = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (hit_way_i[w]) hit_line = hit_line | data_i[w*LINE_W +: LINE_W];
        end
    end

    always_comb begin
        hit_resp            = '0;
        hit_resp.was_unique = ~shared;
        need_upd            = 1'b0;
        hit_op              = UPD_INVALIDATE;
        case (snoop_q)
            SNP_READ_ONCE: begin
                hit_resp.data_transfer = 1'b1;
                hit_resp.is_shared     = 1'b1;
            end
            SNP_READ_SHARED: begin
                hit_resp.data_transfer = 1'b1;
                hit_resp.pass_dirty    = dirty;
                hit_resp.is_shared     = 1'b1;
                need_upd               = 1'b1;
                hit_op                 = UPD_MAKE_SHARED_CLEAN;
            end
            SNP_CLEAN_SHARED: begin
                hit_resp.data_transfer = dirty;
                hit_resp.pass_dirty    = dirty;
                hit_resp.is_shared     = 1'b1;
                need_upd               = 1'b1;
                hit_op                 = UPD_MAKE_SHARED_CLEAN;
            end
            SNP_READ_UNIQUE: begin
                hit_resp.data_transfer = 1'b1;
                hit_resp.pass_dirty    = dirty;
                need_upd               = 1'b1;
            end
            SNP_CLEAN_INVALID: begin
                hit_resp.data_transfer = dirty;
                hit_resp.pass_dirty    = dirty;
                need_upd               = 1'b1;
            end
            SNP_MAKE_INVALID: need_upd = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        snoop_d     = snoop_q;
        resp_d      = resp_q;
        upd_op_d    = upd_op_q;
        ac_ready_o  = 1'b0;
        req_o       = '0;
        upd_valid_o = 1'b0;
        cr_valid_o  = 1'b0;
        load        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ac_ready_o = 1'b1;
                if (ac_valid_i) begin
                    addr_d  = ac_addr_i;
                    snoop_d = ac_snoop_i;
                    resp_d  = '0;
                    if (bypass_i) begin
                        state_d = ST_SEND_CR;
                    end else if (!snoop_supported(ac_snoop_i)) begin
                        resp_d.error = 1'b1;
                        state_d      = ST_SEND_CR;
                    end else begin
                        req_o   = '1;
                        state_d = gnt_i ? ST_LOOKUP : ST_WAIT_GNT;
                    end
                end
            end
            ST_WAIT_GNT: begin
                req_o = '1;
                if (gnt_i) state_d = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                load     = 1'b1;
                resp_d   = hit ? hit_resp : '0;
                upd_op_d = hit_op;
                state_d  = (hit && need_upd) ? ST_UPDATE : ST_SEND_CR;
            end
            ST_UPDATE: begin
                upd_valid_o = 1'b1;
                if (upd_gnt_i) state_d = ST_SEND_CR;
            end
            ST_SEND_CR: begin
                cr_valid_o = 1'b1;
                if (cr_ready_i) state_d = resp_q.data_transfer ? ST_SEND_CD : ST_IDLE;
            end
            ST_SEND_CD: begin
                if (cd_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            snoop_q  <= '0;
            resp_q   <= '0;
            upd_op_q <= UPD_INVALIDATE;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            snoop_q  <= snoop_d;
            resp_q   <= resp_d;
            upd_op_q <= upd_op_d;
        end
    end

    // SRAM sees the incoming address in the handshake cycle so the request needs no extra cycle
    assign addr_o     = ac_hs ? ac_addr_i[INDEX_W-1:0] : addr_q[INDEX_W-1:0];
    assign tag_o      = ac_hs ? ac_addr_i[AW-1:INDEX_W] : addr_q[AW-1:INDEX_W];
    assign busy_o     = (state_q != ST_IDLE);
    assign cr_resp_o  = cr_valid_o ? resp_q : '0;
    assign upd_op_o   = upd_op_q;
    assign upd_addr_o = addr_q;
    assign start_beat = (BEATS == 1) ? '0 : BEAT_W'(addr_q >> OFF_LO);

    snoop_cd_serializer #(
        .DATA_W (DATA_W),
        .LINE_W (LINE_W)
    ) u_cd_ser (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .load_i       (load),
        .line_i       (hit_line),
        .start_beat_i (start_beat),
        .en_i         (state_q == ST_SEND_CD),
        .cd_ready_i   (cd_ready_i),
        .cd_valid_o   (cd_valid_o),
        .cd_data_o    (cd_data_o),
        .cd_last_o    (cd_last_o),
        .done_o       (cd_done)
    );

endmodule

// File: tb/tb_ace_snoop_ctrl.sv
// Directed bench: a 128-bit-line instance driven from a vector table, a 512-bit-line instance for wrap/backpressure/reset.
module tb_ace_snoop_ctrl;

    localparam int AW = 56;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic              rst_a_n, bypass_a, busy_a, ac_valid_a, ac_ready_a;
    logic [AW-1:0]     ac_addr_a, upd_addr_a;
    logic [3:0]        ac_snoop_a;
    logic              cr_valid_a, cr_ready_a, cd_valid_a, cd_ready_a, cd_last_a;
    logic [4:0]        cr_resp_a;
    logic [63:0]       cd_data_a;
    logic [7:0]        req_a, hit_a, dirty_a, shared_a;
    logic [11:0]       addr_a;
    logic [43:0]       tag_a;
    logic              gnt_a, upd_valid_a, upd_op_a, upd_gnt_a;
    logic [8*128-1:0]  data_a;

    logic              rst_b_n, bypass_b, busy_b, ac_valid_b, ac_ready_b;
    logic [AW-1:0]     ac_addr_b, upd_addr_b;
    logic [3:0]        ac_snoop_b;
    logic              cr_valid_b, cr_ready_b, cd_valid_b, cd_ready_b, cd_last_b;
    logic [4:0]        cr_resp_b;
    logic [63:0]       cd_data_b;
    logic [7:0]        req_b, hit_b, dirty_b, shared_b;
    logic [11:0]       addr_b;
    logic [43:0]       tag_b;
    logic              gnt_b, upd_valid_b, upd_op_b, upd_gnt_b;
    logic [8*512-1:0]  data_b;

    ace_snoop_ctrl #(.DATA_W(64), .LINE_W(128), .WAYS(8), .INDEX_W(12), .TAG_W(44)) dut_a (
        .clk_i(clk), .rst_ni(rst_a_n), .bypass_i(bypass_a), .busy_o(busy_a),
        .ac_valid_i(ac_valid_a), .ac_ready_o(ac_ready_a), .ac_addr_i(ac_addr_a), .ac_snoop_i(ac_snoop_a),
        .cr_valid_o(cr_valid_a), .cr_ready_i(cr_ready_a), .cr_resp_o(cr_resp_a),
        .cd_valid_o(cd_valid_a), .cd_ready_i(cd_ready_a), .cd_data_o(cd_data_a), .cd_last_o(cd_last_a),
        .req_o(req_a), .addr_o(addr_a), .tag_o(tag_a), .gnt_i(gnt_a), .data_i(data_a),
        .hit_way_i(hit_a), .dirty_way_i(dirty_a), .shared_way_i(shared_a),
        .upd_valid_o(upd_valid_a), .upd_op_o(upd_op_a), .upd_addr_o(upd_addr_a), .upd_gnt_i(upd_gnt_a));

    ace_snoop_ctrl #(.DATA_W(64), .LINE_W(512), .WAYS(8), .INDEX_W(12), .TAG_W(44)) dut_b (
        .clk_i(clk), .rst_ni(rst_b_n), .bypass_i(bypass_b), .busy_o(busy_b),
        .ac_valid_i(ac_valid_b), .ac_ready_o(ac_ready_b), .ac_addr_i(ac_addr_b), .ac_snoop_i(ac_snoop_b),
        .cr_valid_o(cr_valid_b), .cr_ready_i(cr_ready_b), .cr_resp_o(cr_resp_b),
        .cd_valid_o(cd_valid_b), .cd_ready_i(cd_ready_b), .cd_data_o(cd_data_b), .cd_last_o(cd_last_b),
        .req_o(req_b), .addr_o(addr_b), .tag_o(tag_b), .gnt_i(gnt_b), .data_i(data_b),
        .hit_way_i(hit_b), .dirty_way_i(dirty_b), .shared_way_i(shared_b),
        .upd_valid_o(upd_valid_b), .upd_op_o(upd_op_b), .upd_addr_o(upd_addr_b), .upd_gnt_i(upd_gnt_b));

    function automatic logic [63:0] word(input int w, input int b);
        return {16'hC0DE, 16'(w), 16'h5A5A, 16'(b)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // exp_upd: 0 none, 1 INVALIDATE, 2 MAKE_SHARED_CLEAN
    typedef struct {
        logic [3:0]    snoop;
        logic          bypass;
        logic [AW-1:0] addr;
        logic [7:0]    hit;
        logic [7:0]    dirty;
        logic [7:0]    shared;
        logic [4:0]    exp_resp;
        int            exp_upd;
        logic          exp_req;
        int            exp_beats;
        int            first_beat;
        int            hit_idx;
    } vec_t;

    vec_t vecs[12];

    task automatic run_vec(input vec_t v, input int id);
        int cyc = 0, req_cyc = 0, upd_cyc = 0, cr_cyc = 0, upd_cnt = 0, beats = 0;
        int last_hs = -1, done_cyc = -1, cr_first = -1;
        bit done = 0, req_seen = 0, req_all = 1, addr_ok = 1, hold_ok = 1, rdy_ok = 1, early_cr = 0;
        logic upd_op_seen = 1'b0;
        logic [4:0] resp_seen = '0;
        logic [63:0] got[4];
        logic lastv[4];
        bypass_a = v.bypass; hit_a = v.hit; dirty_a = v.dirty; shared_a = v.shared;
        ac_addr_a = v.addr; ac_snoop_a = v.snoop; ac_valid_a = 1'b1;
        while (!done && cyc < 40) begin
            #1;
            if (cyc == 0) begin
                check($sformatf("v%0d ac_ready", id), ac_ready_a, 1);
                check($sformatf("v%0d hs addr_o", id), addr_a, v.addr[11:0]);
                check($sformatf("v%0d hs tag_o", id), tag_a, v.addr[55:12]);
            end else if (busy_a && ac_ready_a) rdy_ok = 0;
            if (|req_a) begin
                req_seen = 1; req_cyc++;
                if (req_a !== 8'hFF) req_all = 0;
                if (cyc > 0 && (addr_a !== v.addr[11:0] || tag_a !== v.addr[55:12])) addr_ok = 0;
                gnt_a = (req_cyc >= 2);
            end else gnt_a = 1'b0;
            if (upd_valid_a) begin
                upd_cyc++; upd_op_seen = upd_op_a;
                if (upd_addr_a !== v.addr) addr_ok = 0;
                upd_gnt_a = (upd_cyc >= 2);
                if (upd_gnt_a) upd_cnt++;
            end else upd_gnt_a = 1'b0;
            if (cr_valid_a) begin
                if (cr_first < 0) cr_first = cyc;
                if (cr_cyc > 0 && cr_resp_a !== resp_seen) hold_ok = 0;
                if (v.exp_upd != 0 && upd_cnt == 0) early_cr = 1;
                resp_seen = cr_resp_a; cr_cyc++;
                cr_ready_a = (cr_cyc >= 2);
                if (cr_ready_a) last_hs = cyc;
            end else cr_ready_a = 1'b0;
            if (cd_valid_a) begin
                cd_ready_a = 1'b1;
                if (beats < 4) begin got[beats] = cd_data_a; lastv[beats] = cd_last_a; end
                beats++; last_hs = cyc;
            end else cd_ready_a = 1'b0;
            if (cyc > 0 && !busy_a) begin done = 1; done_cyc = cyc; end
            if (!done) begin
                @(posedge clk); #1;
                cyc++; ac_valid_a = 1'b0; ac_addr_a = '0; ac_snoop_a = '0;
            end
        end
        check($sformatf("v%0d completed", id), done, 1);
        check($sformatf("v%0d cr seen", id), cr_first >= 0, 1);
        check($sformatf("v%0d cr_resp", id), resp_seen, v.exp_resp);
        check($sformatf("v%0d req seen", id), req_seen, v.exp_req);
        check($sformatf("v%0d req all ways", id), req_all, 1);
        check($sformatf("v%0d update count", id), upd_cnt, (v.exp_upd != 0) ? 1 : 0);
        if (v.exp_upd != 0) check($sformatf("v%0d update op", id), upd_op_seen, v.exp_upd == 2);
        check($sformatf("v%0d cr before update", id), early_cr, 0);
        check($sformatf("v%0d addr latched", id), addr_ok, 1);
        check($sformatf("v%0d cr stable", id), hold_ok, 1);
        check($sformatf("v%0d ac_ready busy", id), rdy_ok, 1);
        check($sformatf("v%0d idle after last hs", id), done_cyc, last_hs + 1);
        check($sformatf("v%0d beats", id), beats, v.exp_beats);
        for (int i = 0; i < v.exp_beats && i < beats && i < 4; i++) begin
            check($sformatf("v%0d beat%0d data", id, i), got[i], word(v.hit_idx, (v.first_beat + i) % 2));
            check($sformatf("v%0d beat%0d last", id, i), lastv[i], i == v.exp_beats - 1);
        end
        if (v.bypass) check($sformatf("v%0d bypass cr latency", id), cr_first <= 2, 1);
        gnt_a = 1'b0; upd_gnt_a = 1'b0; cr_ready_a = 1'b0; cd_ready_a = 1'b0;
    endtask

    // way 3 hit, ReadOnce at line offset 0x30; cd_ready toggles; optional reset after rst_after beats
    task automatic run_b(input int rst_after);
        int cyc = 0, beats = 0, cdc = 0;
        bit done = 0, stall = 0, upd_seen = 0, stop = 0;
        logic [63:0] held = '0;
        ac_addr_b = 56'h000000ABCD1030; ac_snoop_b = 4'b0000;
        hit_b = 8'h08; dirty_b = 8'h00; shared_b = 8'h00; ac_valid_b = 1'b1;
        while (!done && !stop && cyc < 80) begin
            #1;
            gnt_b = |req_b;
            if (upd_valid_b) upd_seen = 1;
            cr_ready_b = cr_valid_b;
            if (cr_valid_b) check("b cr_resp", cr_resp_b, 5'b11001);
            if (cd_valid_b) begin
                if (stall) check($sformatf("b beat%0d held", beats), cd_data_b, held);
                cd_ready_b = cdc[0]; cdc++;
                if (cd_ready_b) begin
                    check($sformatf("b beat%0d data", beats), cd_data_b, word(3, (6 + beats) % 8));
                    check($sformatf("b beat%0d last", beats), cd_last_b, beats == 7);
                    beats++; stall = 0;
                end else begin
                    stall = 1; held = cd_data_b;
                end
            end else cd_ready_b = 1'b0;
            if (cyc > 0 && !busy_b) done = 1;
            if (!done) begin
                @(posedge clk); #1;
                cyc++; ac_valid_b = 1'b0; ac_addr_b = '0;
                if (rst_after > 0 && beats >= rst_after) stop = 1;
            end
        end
        cd_ready_b = 1'b0; gnt_b = 1'b0; cr_ready_b = 1'b0;
        check("b no update", upd_seen, 0);
        if (rst_after == 0) begin
            check("b completed", done, 1);
            check("b beat count", beats, 8);
        end else begin
            check("b in SEND_CD before reset", {stop, cd_valid_b}, 2'b11);
            rst_b_n = 1'b0;
            #1;
            check("b rst cd_valid", cd_valid_b, 0);
            check("b rst ac_ready", ac_ready_b, 1);
            check("b rst busy", busy_b, 0);
            #2 rst_b_n = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                check($sformatf("b post-rst outputs c%0d", i),
                      {busy_b, ac_ready_b, cd_valid_b, cr_valid_b, upd_valid_b}, 5'b01000);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        {bypass_a, ac_valid_a, cr_ready_a, cd_ready_a, gnt_a, upd_gnt_a} = '0;
        {bypass_b, ac_valid_b, cr_ready_b, cd_ready_b, gnt_b, upd_gnt_b} = '0;
        ac_addr_a = '0; ac_snoop_a = '0; hit_a = '0; dirty_a = '0; shared_a = '0;
        ac_addr_b = '0; ac_snoop_b = '0; hit_b = '0; dirty_b = '0; shared_b = '0;
        for (int w = 0; w < 8; w++) begin
            for (int b = 0; b < 2; b++) data_a[w*128 + b*64 +: 64] = word(w, b);
            for (int b = 0; b < 8; b++) data_b[w*512 + b*64 +: 64] = word(w, b);
        end

        vecs[0]  = '{4'b0001, 1'b0, 56'h00000000001008, 8'h04, 8'h00, 8'h00, 5'b11001, 2, 1'b1, 2, 1, 2};
        vecs[1]  = '{4'b1001, 1'b0, 56'h00ABCDEF001008, 8'h20, 8'h20, 8'h00, 5'b10101, 1, 1'b1, 2, 1, 5};
        vecs[2]  = '{4'b1001, 1'b0, 56'h00000000005008, 8'h20, 8'h01, 8'h80, 5'b10000, 1, 1'b1, 0, 0, 5};
        vecs[3]  = '{4'b0010, 1'b0, 56'h00000000000040, 8'h01, 8'h01, 8'h00, 5'b00010, 0, 1'b0, 0, 0, 0};
        vecs[4]  = '{4'b0111, 1'b1, 56'h00000000001008, 8'h01, 8'h01, 8'h00, 5'b00000, 0, 1'b0, 0, 0, 0};
        vecs[5]  = '{4'b0111, 1'b0, 56'h000000000FF008, 8'h00, 8'hFF, 8'hFF, 5'b00000, 0, 1'b1, 0, 0, 0};
        vecs[6]  = '{4'b0000, 1'b0, 56'h00000000001000, 8'h01, 8'h01, 8'h01, 5'b01001, 0, 1'b1, 2, 0, 0};
        vecs[7]  = '{4'b0111, 1'b0, 56'h00000000002008, 8'h80, 8'h80, 8'h80, 5'b00101, 1, 1'b1, 2, 1, 7};
        vecs[8]  = '{4'b1000, 1'b0, 56'h00000000003000, 8'h08, 8'h08, 8'h00, 5'b11101, 2, 1'b1, 2, 0, 3};
        vecs[9]  = '{4'b1000, 1'b0, 56'h00000000003008, 8'h02, 8'h00, 8'h02, 5'b01000, 2, 1'b1, 0, 0, 1};
        vecs[10] = '{4'b1101, 1'b0, 56'h00000000004000, 8'h10, 8'h10, 8'h00, 5'b10000, 1, 1'b1, 0, 0, 4};
        vecs[11] = '{4'b1111, 1'b0, 56'h00000000006008, 8'h01, 8'h00, 8'h00, 5'b00010, 0, 1'b0, 0, 0, 0};

        #2;
        check("rst ac_ready", ac_ready_a, 1);
        check("rst busy/valids", {busy_a, cr_valid_a, cd_valid_a, upd_valid_a, cd_last_a, upd_op_a}, 6'b0);
        check("rst req_o", req_a, 0);
        check("rst cr_resp", cr_resp_a, 0);
        check("rst cd_data", cd_data_a, 0);
        check("rst addr/tag", {addr_a, tag_a}, 0);
        check("rst upd_addr", upd_addr_a, 0);

        #20 rst_a_n = 1'b1; rst_b_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        run_b(0);
        @(posedge clk); #1;
        run_b(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
